// File: rtl/inst_fetch_buf_pkg.sv
// Shared constants and entry type for the instruction fetch buffer.
// Optional feature macro used by the top: IF_PERF_EN (perf counters).
package inst_fetch_buf_pkg;

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buf_fetch_fifo.sv
// Synchronous prefetch FIFO; clear has priority over push and pop.
// Power-of-two depth so read/write pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    // a push into a full FIFO is accepted only when the head leaves on the same edge
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/inst_fetch_buf.sv
// Fetch stage: issues sync imem reads under a credit rule, buffers {pc, inst} for decode.
// Define IF_PERF_EN to add perf_fetch / perf_flush counters.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter logic [31:0] RESET_PC   = IF_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jmp_vld,
    input  logic [31:0]       jmp_addr,
    input  logic              nop,
    output logic [ADDR_W-3:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       pc,
    output logic [31:0]       inst
`ifdef IF_PERF_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_flush
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]  fpc_q, fpc_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_pc_q, pend_pc_d;

    logic [31:0]  target;
    logic         pop, push, credit_ok;
    logic [CW:0]  in_flight;
    fetch_entry_t push_entry, head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;

    assign target     = jmp_addr & ~32'h3;
    assign inst_valid = ~fifo_empty;
    assign pop        = inst_valid & inst_ready & ~jmp_vld;
    // a response landing on a redirect edge belongs to the old stream and is dropped
    assign push       = pend_q & ~jmp_vld;
    assign push_entry = '{pc: pend_pc_q, inst: imem_rdata};

    always_comb begin
        in_flight = {1'b0, fifo_count} - (CW+1)'(pop) + (CW+1)'(pend_q);
        credit_ok = (in_flight < (CW+1)'(FIFO_DEPTH));
        imem_en   = rst_n & (jmp_vld | credit_ok);
        imem_addr = jmp_vld ? jmp_addr[ADDR_W-1:2] : fpc_q[ADDR_W-1:2];
    end

    always_comb begin
        fpc_d     = fpc_q;
        pend_d    = imem_en;
        pend_pc_d = jmp_vld ? target : fpc_q;
        if (jmp_vld) begin
            fpc_d = target + 32'd4;
        end else if (imem_en) begin
            fpc_d = fpc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_q     <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            fpc_q     <= fpc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (jmp_vld),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        pc   = inst_valid ? head.pc : '0;
        inst = (inst_valid && !nop) ? head.inst : INST_NOP;
    end

    push_into_full_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(pop);
        perf_flush_d = perf_flush_q + 32'(jmp_vld);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf with a sync-read memory and a pc-stream reference model.
// Build with +define+IF_PERF_EN to also check the perf counters.
module tb_inst_fetch_buf;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jmp_vld = 1'b0;
    logic [31:0] jmp_addr = '0;
    logic        nop = 1'b0;
    logic [9:0]  imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] inst;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    inst_fetch_buf #(
        .ADDR_W     (12),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .jmp_vld    (jmp_vld),
        .jmp_addr   (jmp_addr),
        .nop        (nop),
        .imem_addr  (imem_addr),
        .imem_en    (imem_en),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pc         (pc),
        .inst       (inst)
`ifdef IF_PERF_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_flush (perf_flush)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // leaves the bench 1 time unit after the reset edge with rst_n released (cycle C0)
    task automatic do_reset();
        rst_n   = 1'b0;
        jmp_vld = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inst_ready = 1'b1; nop = 1'b0; jmp_vld = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || pc !== 32'h0 || inst !== NOP || imem_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_state valid=%b pc=%h inst=%h en=%b required 0/0/%h/0",
                     inst_valid, pc, inst, imem_en, NOP);
        end
    endtask

    task automatic test_stream();
        inst_ready = 1'b1; nop = 1'b0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (imem_en !== 1'b1 || imem_addr !== 10'(k)) begin
                failures++;
                $display("FAIL stream_issue cyc=%0d en=%b addr=%0d required 1/%0d", k, imem_en, imem_addr, k);
            end
            checks++;
            if (inst_valid !== (k >= 2)) begin
                failures++;
                $display("FAIL stream_valid cyc=%0d got=%b required=%b", k, inst_valid, (k >= 2));
            end
            if (k >= 2) begin
                checks++;
                if (pc !== 32'(4 * (k - 2)) || inst !== mem[k-2]) begin
                    failures++;
                    $display("FAIL stream_head cyc=%0d pc=%h inst=%h required %h/%h",
                             k, pc, inst, 32'(4 * (k - 2)), mem[k-2]);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0; nop = 1'b0;
        do_reset();
        repeat (10) step();
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b0 || inst_valid !== 1'b1 || pc !== 32'h0) begin
            failures++;
            $display("FAIL hold_full en=%b valid=%b pc=%h required 0/1/0", imem_en, inst_valid, pc);
        end
        step();
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || pc !== 32'(4 * k) || inst !== mem[k]) begin
                failures++;
                $display("FAIL drain k=%0d valid=%b pc=%h inst=%h required 1/%h/%h",
                         k, inst_valid, pc, inst, 32'(4 * k), mem[k]);
            end
            step();
        end
    endtask

    task automatic test_jump_flush();
        inst_ready = 1'b0; nop = 1'b0;
        do_reset();
        repeat (4) step();
        jmp_vld = 1'b1; jmp_addr = 32'h104;
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 10'h41) begin
            failures++;
            $display("FAIL jump_issue en=%b addr=%h required 1/041", imem_en, imem_addr);
        end
        step();
        jmp_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || pc !== 32'h0) begin
            failures++;
            $display("FAIL jump_gap valid=%b pc=%h required 0/0", inst_valid, pc);
        end
        step();
        inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || pc !== 32'h104 || inst !== mem[10'h41]) begin
            failures++;
            $display("FAIL jump_target valid=%b pc=%h inst=%h required 1/104/%h", inst_valid, pc, inst, mem[10'h41]);
        end
        step();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || pc !== 32'h108) begin
            failures++;
            $display("FAIL jump_next valid=%b pc=%h required 1/108", inst_valid, pc);
        end
    endtask

    task automatic test_jump_beats_pop();
        inst_ready = 1'b1; nop = 1'b0;
        do_reset();
        repeat (4) step();
        jmp_vld = 1'b1; jmp_addr = 32'h200;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || pc !== 32'h8) begin
            failures++;
            $display("FAIL jbp_head valid=%b pc=%h required 1/8", inst_valid, pc);
        end
        step();
        jmp_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL jbp_flushed valid=%b required 0", inst_valid);
        end
`ifdef IF_PERF_EN
        checks++;
        if (perf_fetch !== 32'd2 || perf_flush !== 32'd1) begin
            failures++;
            $display("FAIL jbp_perf fetch=%0d flush=%0d required 2/1", perf_fetch, perf_flush);
        end
`endif
        step();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || pc !== 32'h200 || inst !== mem[10'h80]) begin
            failures++;
            $display("FAIL jbp_target valid=%b pc=%h inst=%h required 1/200/%h", inst_valid, pc, inst, mem[10'h80]);
        end
    endtask

    task automatic test_nop();
        inst_ready = 1'b1; nop = 1'b0;
        do_reset();
        repeat (4) step();
        inst_ready = 1'b0; nop = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || pc !== 32'h8 || inst !== NOP) begin
            failures++;
            $display("FAIL nop_on valid=%b pc=%h inst=%h required 1/8/%h", inst_valid, pc, inst, NOP);
        end
        step();
        nop = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || pc !== 32'h8 || inst !== mem[2]) begin
            failures++;
            $display("FAIL nop_off valid=%b pc=%h inst=%h required 1/8/%h", inst_valid, pc, inst, mem[2]);
        end
    endtask

    task automatic test_reset_midstream();
        inst_ready = 1'b1; nop = 1'b0;
        do_reset();
        jmp_vld = 1'b1; jmp_addr = 32'hFF4;
        step();
        jmp_vld = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'd0) begin
            failures++;
            $display("FAIL rstmid_c0 valid=%b en=%b addr=%0d required 0/1/0", inst_valid, imem_en, imem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_stale valid=%b pc=%h required 0", inst_valid, pc);
        end
        step();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== mem[0]) begin
            failures++;
            $display("FAIL rstmid_first valid=%b pc=%h inst=%h required 1/0/%h", inst_valid, pc, inst, mem[0]);
        end
    endtask

    task automatic test_wrap();
        logic [9:0]  exp_addr [5];
        logic [31:0] exp_pc   [5];
        exp_addr = '{10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2};
        exp_pc   = '{32'h0, 32'h0, 32'hFF8, 32'hFFC, 32'h1000};
        inst_ready = 1'b1; nop = 1'b0;
        do_reset();
        jmp_vld = 1'b1; jmp_addr = 32'hFF8;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (imem_en !== 1'b1 || imem_addr !== exp_addr[k]) begin
                failures++;
                $display("FAIL wrap_addr k=%0d addr=%0d required %0d", k, imem_addr, exp_addr[k]);
            end
            if (k >= 2) begin
                checks++;
                if (inst_valid !== 1'b1 || pc !== exp_pc[k] || inst !== mem[exp_pc[k][11:2]]) begin
                    failures++;
                    $display("FAIL wrap_head k=%0d pc=%h inst=%h required %h/%h",
                             k, pc, inst, exp_pc[k], mem[exp_pc[k][11:2]]);
                end
            end
            step();
            jmp_vld = 1'b0;
        end
    endtask

    // model: head pc is a linear stream that restarts at each redirect target
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        int          since;
        int          exp_fetch;
        int          exp_flush;
        exp_pc = 32'h0; since = -1; exp_fetch = 0; exp_flush = 0;
        inst_ready = 1'b1; nop = 1'b0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n > 0) begin
                step();
                inst_ready = ($urandom % 4) != 0;
                nop        = ($urandom % 8) == 0;
                jmp_vld    = ($urandom % 20) == 0;
                jmp_addr   = $urandom;
            end
            @(negedge clk);
            if (since >= 1) begin
                checks++;
                if (inst_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_starve n=%0d valid=%b required 1", n, inst_valid);
                end
            end
            exp_inst = nop ? NOP : mem[exp_pc[11:2]];
            checks++;
            if (inst_valid === 1'b1) begin
                if (pc !== exp_pc || inst !== exp_inst) begin
                    failures++;
                    $display("FAIL rand_head n=%0d pc=%h inst=%h required %h/%h", n, pc, inst, exp_pc, exp_inst);
                end
            end else if (pc !== 32'h0 || inst !== NOP) begin
                failures++;
                $display("FAIL rand_idle n=%0d pc=%h inst=%h required 0/%h", n, pc, inst, NOP);
            end
            if (jmp_vld) begin
                exp_pc = jmp_addr & ~32'h3;
                since  = 0;
                exp_flush++;
            end else begin
                if (inst_valid === 1'b1 && inst_ready) begin
                    exp_pc = exp_pc + 32'd4;
                    exp_fetch++;
                end
                since++;
            end
        end
        step();
        jmp_vld = 1'b0; inst_ready = 1'b0; nop = 1'b0;
        @(negedge clk);
`ifdef IF_PERF_EN
        checks++;
        if (perf_fetch !== 32'(exp_fetch) || perf_flush !== 32'(exp_flush)) begin
            failures++;
            $display("FAIL rand_perf fetch=%0d flush=%0d required %0d/%0d", perf_fetch, perf_flush, exp_fetch, exp_flush);
        end
`endif
        checks++;
        if (inst_valid === 1'b1 && pc !== exp_pc) begin
            failures++;
            $display("FAIL rand_final pc=%h required %h", pc, exp_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        test_reset();
        test_stream();
        test_backpressure();
        test_jump_flush();
        test_jump_beats_pop();
        test_nop();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
